cpoly_arb_sched: RTL

CPOLY_ARB_SCHED -- requirements
Module: cpoly_arb_sched

---
 rtl/cpoly_arb_sched_pkg.sv | 28 ++
 rtl/cpoly_arb_sched_if.sv | 32 +++
 rtl/cpoly_arb_sched_cmul.sv | 21 ++
 rtl/cpoly_arb_sched.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/cpoly_arb_sched_pkg.sv
// Shared widths, sequencing counts, FSM states and the complex result type
// for the two-requester conjugate-product scheduler.
package cpoly_arb_sched_pkg;

  localparam int OP_W       = 8;
  localparam int RES_W      = 18;
  localparam int WORD_W     = 2 * OP_W;
  localparam int OUT_W      = 2 * RES_W;

  localparam int LOAD_BEATS = 4;
  localparam int CALC_STEPS = 4;
  localparam int OUT_BEATS  = 3;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    LOAD,
    CALC,
    OUT
  } st_e;

  // Packed so that {re, im} lines up directly with the 36-bit result bus.
  typedef struct packed {
    logic signed [RES_W-1:0] re;
    logic signed [RES_W-1:0] im;
  } cplx_t;

endpackage

// File: rtl/cpoly_arb_sched_if.sv
// Request/operand/result bundle between the requesters and the scheduler.
//
// Handshake: req_0/req_1 are levels held by a requester until it sees its
// gnt bit, which is a single-cycle pulse. in_valid qualifies 'in' on a
// rising edge and is only consumed while the scheduler is loading. out_valid
// qualifies 'out'/'out_id' for one beat per cycle; there is no back-pressure,
// and out/out_id read as zero whenever out_valid is low.
interface cpoly_arb_sched_if
  import cpoly_arb_sched_pkg::*;
  ();

  logic              req_0;
  logic              req_1;
  logic [1:0]        gnt;
  logic              in_valid;
  logic [WORD_W-1:0] in;
  logic              busy;
  logic              out_valid;
  logic [OUT_W-1:0]  out;
  logic              out_id;

  modport master (
    output req_0, req_1, in_valid, in,
    input  gnt, busy, out_valid, out, out_id
  );

  modport slave (
    input  req_0, req_1, in_valid, in,
    output gnt, busy, out_valid, out, out_id
  );

endinterface

// File: rtl/cpoly_arb_sched_cmul.sv
// Combinational conjugate product p = conj(x) * y on 8-bit signed complex
// operands packed {re, im}; every term is carried at 18 bits so no sum wraps.
module cplx_conj_mul
  import cpoly_arb_sched_pkg::*;
(
  input  logic [WORD_W-1:0] x_i,
  input  logic [WORD_W-1:0] y_i,
  output cplx_t             p_o
);

  logic signed [RES_W-1:0] xr, xi, yr, yi;

  assign xr = RES_W'($signed(x_i[WORD_W-1:OP_W]));
  assign xi = RES_W'($signed(x_i[OP_W-1:0]));
  assign yr = RES_W'($signed(y_i[WORD_W-1:OP_W]));
  assign yi = RES_W'($signed(y_i[OP_W-1:0]));

  assign p_o.re = xr * yr + xi * yi;
  assign p_o.im = xr * yi - xi * yr;

endmodule

// File: rtl/cpoly_arb_sched.sv
// Round-robin scheduler for two requesters sharing one conjugate multiplier:
// grant, load a0/a1/b0/b1, compute c0/c1/c2 over four steps, emit three beats.
module cpoly_arb_sched
  import cpoly_arb_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  cpoly_arb_sched_if.slave       bus,
  output st_e                    dbg_state_o
);

  st_e               state_q;
  logic              ptr_q;
  logic              winner_q;
  logic              winner_d;
  logic [1:0]        gnt_q;
  logic [1:0]        beat_cnt_q;
  logic [1:0]        step_cnt_q;
  logic [1:0]        out_cnt_q;
  logic [WORD_W-1:0] a0_q, a1_q, b0_q, b1_q;
  logic [WORD_W-1:0] mul_x, mul_y;
  cplx_t             prod;
  cplx_t             c0_q, acc1_q, c2_q;
  logic              out_valid_q;
  logic              out_id_q;
  logic [OUT_W-1:0]  out_q;

  // Arbitration: a lone requester wins outright; on a tie the pointer decides.
  always_comb begin
    winner_d = 1'b0;
    if (bus.req_0 && bus.req_1) winner_d = ptr_q;
    else if (bus.req_1)         winner_d = 1'b1;
  end

  // Operand pair for the current calculation step.
  always_comb begin
    mul_x = a0_q;
    mul_y = b0_q;
    case (step_cnt_q)
      2'd0:    begin mul_x = a0_q; mul_y = b0_q; end
      2'd1:    begin mul_x = a0_q; mul_y = b1_q; end
      2'd2:    begin mul_x = a1_q; mul_y = b0_q; end
      default: begin mul_x = a1_q; mul_y = b1_q; end
    endcase
  end

  cplx_conj_mul u_mul (
    .x_i (mul_x),
    .y_i (mul_y),
    .p_o (prod)
  );

  // Scheduler FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      winner_q    <= 1'b0;
      gnt_q       <= 2'b00;
      beat_cnt_q  <= 2'd0;
      step_cnt_q  <= 2'd0;
      out_cnt_q   <= 2'd0;
      a0_q        <= '0;
      a1_q        <= '0;
      b0_q        <= '0;
      b1_q        <= '0;
      c0_q        <= '0;
      acc1_q      <= '0;
      c2_q        <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      out_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_0 || bus.req_1) begin
            winner_q <= winner_d;
            gnt_q    <= winner_d ? 2'b10 : 2'b01;
            state_q  <= GRANT;
          end
        end
        GRANT: begin
          gnt_q      <= 2'b00;
          beat_cnt_q <= 2'd0;
          state_q    <= LOAD;
        end
        LOAD: begin
          if (bus.in_valid) begin
            case (beat_cnt_q)
              2'd0:    a0_q <= bus.in;
              2'd1:    a1_q <= bus.in;
              2'd2:    b0_q <= bus.in;
              default: b1_q <= bus.in;
            endcase
            beat_cnt_q <= beat_cnt_q + 2'd1;
            if (beat_cnt_q == 2'(LOAD_BEATS - 1)) begin
              step_cnt_q <= 2'd0;
              state_q    <= CALC;
            end
          end
        end
        CALC: begin
          case (step_cnt_q)
            2'd0: c0_q   <= prod;
            2'd1: acc1_q <= prod;
            2'd2: begin
              acc1_q.re <= acc1_q.re + prod.re;
              acc1_q.im <= acc1_q.im + prod.im;
            end
            default: c2_q <= prod;
          endcase
          step_cnt_q <= step_cnt_q + 2'd1;
          if (step_cnt_q == 2'(CALC_STEPS - 1)) begin
            out_cnt_q <= 2'd0;
            state_q   <= OUT;
          end
        end
        OUT: begin
          // First OUT cycle stages c0; the job closes once all beats are out.
          if (out_cnt_q == 2'(OUT_BEATS)) begin
            out_valid_q <= 1'b0;
            out_id_q    <= 1'b0;
            out_q       <= '0;
            ptr_q       <= ~winner_q;
            state_q     <= IDLE;
          end else begin
            out_valid_q <= 1'b1;
            out_id_q    <= winner_q;
            case (out_cnt_q)
              2'd0:    out_q <= c0_q;
              2'd1:    out_q <= acc1_q;
              default: out_q <= c2_q;
            endcase
            out_cnt_q <= out_cnt_q + 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.out_id    = out_id_q;
  assign dbg_state_o   = state_q;

endmodule
